lc3_mem_ctrl: RTL and testbench

//  Memory/IO controller directly upstream of the LC-3 datapath's MDR. Takes MAR/MDR plus a

---
 rtl/lc3_mem_pkg.sv | 16 +
 rtl/lc3_mem_ctrl_wait_counter.sv | 29 ++
 rtl/lc3_mem_ctrl.sv | 138 +++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared types and defaults for the LC-3 memory/IO controller.
package lc3_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_IO_RD   = 3'd3,
        ST_IO_WR   = 3'd4,
        ST_DONE    = 3'd5
    } mem_state_t;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
    localparam int          SRAM_AW_DEFAULT = 20;

endpackage

// File: rtl/lc3_mem_ctrl_wait_counter.sv
// Up-counter timing the SRAM strobe window; tc flags the last strobe cycle.
module mem_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic Clk,
    input  logic Reset_al,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] TC_VAL = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge Clk) begin
        if (!Reset_al) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory/IO controller: wait-stated async SRAM cycles plus one
// memory-mapped IO address (switches on read, hex display on write).
//
// state      | meaning
// IDLE       | waiting for MEM_RD/MEM_WR, counter held clear
// RD_WAIT    | SRAM read, CE_n/OE_n low
// WR_WAIT    | SRAM write, CE_n/WE_n low
// IO_RD      | capture switches
// IO_WR      | load hex-display register
// DONE       | R pulse, strobes released
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT,
    parameter int          SRAM_AW     = SRAM_AW_DEFAULT
) (
    input  logic               Clk,
    input  logic               Reset_al,
    input  logic               MEM_RD,
    input  logic               MEM_WR,
    input  logic [15:0]        MAR,
    input  logic [15:0]        MDR,
    input  logic [15:0]        Switches,
    input  logic [15:0]        Data_from_SRAM,
    output logic [15:0]        MDR_In,
    output logic               R,
    output logic               Busy,
    output logic [15:0]        HEX_Data,
    output logic [SRAM_AW-1:0] ADDR,
    output logic [15:0]        Data_to_SRAM,
    output logic               CE_n,
    output logic               OE_n,
    output logic               WE_n,
    output logic               UB_n,
    output logic               LB_n
);

    mem_state_t  state;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        cnt_clr;
    logic        cnt_en;
    logic        cnt_tc;

    assign cnt_clr = (state == ST_IDLE);
    assign cnt_en  = (state == ST_RD_WAIT) || (state == ST_WR_WAIT);

    mem_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .Clk      (Clk),
        .Reset_al (Reset_al),
        .clear    (cnt_clr),
        .enable   (cnt_en),
        .tc       (cnt_tc)
    );

    assign ADDR         = {{(SRAM_AW-16){1'b0}}, addr_q};
    assign Data_to_SRAM = wdata_q;

    always_ff @(posedge Clk) begin
        if (!Reset_al) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            MDR_In   <= '0;
            HEX_Data <= '0;
            R        <= 1'b0;
            Busy     <= 1'b0;
            CE_n     <= 1'b1;
            OE_n     <= 1'b1;
            WE_n     <= 1'b1;
            UB_n     <= 1'b1;
            LB_n     <= 1'b1;
        end else begin
            R <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (MEM_RD || MEM_WR) begin
                        addr_q  <= MAR;
                        wdata_q <= MDR;
                        Busy    <= 1'b1;
                        if (MAR == IO_ADDR) begin
                            state <= MEM_RD ? ST_IO_RD : ST_IO_WR;
                        end else begin
                            // strobes are registered, so drive them on entry to the wait state
                            state <= MEM_RD ? ST_RD_WAIT : ST_WR_WAIT;
                            CE_n  <= 1'b0;
                            UB_n  <= 1'b0;
                            LB_n  <= 1'b0;
                            OE_n  <= !MEM_RD;
                            WE_n  <= MEM_RD;
                        end
                    end
                end
                ST_RD_WAIT, ST_WR_WAIT: begin
                    if (cnt_tc) begin
                        if (state == ST_RD_WAIT) begin
                            MDR_In <= Data_from_SRAM;
                        end
                        state <= ST_DONE;
                        R     <= 1'b1;
                        CE_n  <= 1'b1;
                        OE_n  <= 1'b1;
                        WE_n  <= 1'b1;
                        UB_n  <= 1'b1;
                        LB_n  <= 1'b1;
                    end
                end
                ST_IO_RD: begin
                    MDR_In <= Switches;
                    state  <= ST_DONE;
                    R      <= 1'b1;
                end
                ST_IO_WR: begin
                    HEX_Data <= wdata_q;
                    state    <= ST_DONE;
                    R        <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                    CE_n  <= 1'b1;
                    OE_n  <= 1'b1;
                    WE_n  <= 1'b1;
                    UB_n  <= 1'b1;
                    LB_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: directed cases plus random accesses
// checked against a transaction-level model of latency, strobes and registers.
module tb_lc3_mem_ctrl;

    localparam int W = 2;

    logic        Clk = 1'b0;
    logic        Reset_al = 1'b0;
    logic        MEM_RD = 1'b0;
    logic        MEM_WR = 1'b0;
    logic [15:0] MAR = '0;
    logic [15:0] MDR = '0;
    logic [15:0] Switches = '0;
    logic [15:0] Data_from_SRAM = '0;
    logic [15:0] MDR_In;
    logic        R;
    logic        Busy;
    logic [15:0] HEX_Data;
    logic [19:0] ADDR;
    logic [15:0] Data_to_SRAM;
    logic        CE_n, OE_n, WE_n, UB_n, LB_n;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] m_mdr_in = '0;
    logic [15:0] m_hex = '0;

    lc3_mem_ctrl #(
        .WAIT_CYCLES (W),
        .IO_ADDR     (16'hFFFF),
        .SRAM_AW     (20)
    ) dut (
        .Clk            (Clk),
        .Reset_al       (Reset_al),
        .MEM_RD         (MEM_RD),
        .MEM_WR         (MEM_WR),
        .MAR            (MAR),
        .MDR            (MDR),
        .Switches       (Switches),
        .Data_from_SRAM (Data_from_SRAM),
        .MDR_In         (MDR_In),
        .R              (R),
        .Busy           (Busy),
        .HEX_Data       (HEX_Data),
        .ADDR           (ADDR),
        .Data_to_SRAM   (Data_to_SRAM),
        .CE_n           (CE_n),
        .OE_n           (OE_n),
        .WE_n           (WE_n),
        .UB_n           (UB_n),
        .LB_n           (LB_n)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One request cycle, then watch the whole access and compare against the model.
    task automatic access(input logic rd, input logic wr, input logic [15:0] mar,
                          input logic [15:0] mdr, input logic [15:0] sdata,
                          input logic [15:0] sw, input bit poke);
        bit   io;
        int   lat, n, r_idx, r_cnt, oe_c, we_c, ce_c, be_c, addr_bad;
        logic busy0, busyl;
        io    = (mar == 16'hFFFF);
        lat   = io ? 2 : W + 1;
        n     = lat + W + 4;
        r_idx = -1;
        r_cnt = 0; oe_c = 0; we_c = 0; ce_c = 0; be_c = 0; addr_bad = 0;
        busy0 = 1'b0; busyl = 1'b1;
        @(negedge Clk);
        MEM_RD = rd; MEM_WR = wr; MAR = mar; MDR = mdr;
        Data_from_SRAM = sdata; Switches = sw;
        for (int i = 0; i < n; i++) begin
            @(posedge Clk); #1;
            if (i == 0) begin
                MEM_RD = 1'b0; MEM_WR = 1'b0; MAR = ~mar; MDR = ~mdr;
            end
            if (R) begin
                r_cnt++;
                if (r_idx < 0) r_idx = i;
            end
            if (!OE_n) oe_c++;
            if (!WE_n) we_c++;
            if (!CE_n) ce_c++;
            if (!UB_n && !LB_n) be_c++;
            if (!CE_n && ADDR !== {4'h0, mar}) addr_bad++;
            if (i == 0) busy0 = Busy;
            if (i == lat) busyl = Busy;
            if (poke && i == 1) MEM_WR = 1'b1;
            if (poke && i == 2) MEM_WR = 1'b0;
        end
        if (rd) m_mdr_in = io ? sw : sdata;
        else if (io) m_hex = mdr;
        chk("r_edge", 32'(r_idx), 32'(lat - 1));
        chk("r_count", 32'(r_cnt), 32'd1);
        chk("oe_cycles", 32'(oe_c), (!io && rd) ? 32'(W) : 32'd0);
        chk("we_cycles", 32'(we_c), (!io && !rd) ? 32'(W) : 32'd0);
        chk("ce_cycles", 32'(ce_c), io ? 32'd0 : 32'(W));
        chk("byte_en_cycles", 32'(be_c), io ? 32'd0 : 32'(W));
        chk("addr_during_strobe", 32'(addr_bad), 32'd0);
        chk("addr_latched", 32'(ADDR), 32'({4'h0, mar}));
        chk("data_to_sram", 32'(Data_to_SRAM), 32'(mdr));
        chk("busy_start", 32'(busy0), 32'd1);
        chk("busy_end", 32'(busyl), 32'd0);
        chk("mdr_in", 32'(MDR_In), 32'(m_mdr_in));
        chk("hex_data", 32'(HEX_Data), 32'(m_hex));
    endtask

    initial begin
        logic [15:0] sd;
        int          r_cnt, r_bad, n_acc;
        bit          exp_r [0:19];

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_ce", 32'(CE_n), 32'd1);
        chk("rst_oe", 32'(OE_n), 32'd1);
        chk("rst_we", 32'(WE_n), 32'd1);
        chk("rst_bytes", 32'({UB_n, LB_n}), 32'd3);
        chk("rst_r", 32'(R), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_mdr_in", 32'(MDR_In), 32'd0);
        chk("rst_hex", 32'(HEX_Data), 32'd0);
        chk("rst_addr", 32'(ADDR), 32'd0);
        chk("rst_wdata", 32'(Data_to_SRAM), 32'd0);
        Reset_al = 1'b1;

        access(1'b1, 1'b0, 16'h3000, 16'h0000, 16'hBEEF, 16'h0000, 1'b0);
        access(1'b0, 1'b1, 16'h1234, 16'hA5A5, 16'h1111, 16'h0000, 1'b0);
        access(1'b0, 1'b1, 16'hFFFF, 16'h00C3, 16'h2222, 16'h0000, 1'b0);
        access(1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h3333, 16'h0055, 1'b0);
        access(1'b1, 1'b1, 16'h4321, 16'h7777, 16'hCAFE, 16'h0000, 1'b0);
        access(1'b1, 1'b0, 16'h0042, 16'h0000, 16'h6B6B, 16'h0000, 1'b1);
        access(1'b0, 1'b1, 16'hFFFF, 16'h0099, 16'h0000, 16'h0000, 1'b1);

        // reset in the middle of an SRAM read
        @(negedge Clk);
        MEM_RD = 1'b1; MAR = 16'h4000; Data_from_SRAM = 16'h5A5A;
        @(posedge Clk); #1;
        MEM_RD = 1'b0;
        Reset_al = 1'b0;
        @(posedge Clk); #1;
        chk("midrst_ce", 32'(CE_n), 32'd1);
        chk("midrst_oe", 32'(OE_n), 32'd1);
        chk("midrst_r", 32'(R), 32'd0);
        chk("midrst_busy", 32'(Busy), 32'd0);
        chk("midrst_mdr_in", 32'(MDR_In), 32'd0);
        chk("midrst_hex", 32'(HEX_Data), 32'd0);
        Reset_al = 1'b1;
        m_mdr_in = '0;
        m_hex = '0;
        r_cnt = 0;
        repeat (W + 3) begin
            @(posedge Clk); #1;
            if (R) r_cnt++;
        end
        chk("midrst_no_r", 32'(r_cnt), 32'd0);
        access(1'b1, 1'b0, 16'h4000, 16'h0000, 16'h0F0F, 16'h0000, 1'b0);

        // request held for 6 edges: accepts at t=0, W+2, ... while still high
        for (int i = 0; i < 20; i++) exp_r[i] = 1'b0;
        n_acc = 0;
        for (int t = 0; t < 6; t += W + 2) begin
            exp_r[t + W] = 1'b1;
            n_acc++;
        end
        sd = 16'($urandom);
        @(negedge Clk);
        MEM_RD = 1'b1; MAR = 16'h2468; Data_from_SRAM = sd;
        r_cnt = 0; r_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk); #1;
            if (i == 5) MEM_RD = 1'b0;
            if (R) r_cnt++;
            if (R !== exp_r[i]) r_bad++;
        end
        m_mdr_in = sd;
        chk("held_r_count", 32'(r_cnt), 32'(n_acc));
        chk("held_r_timing", 32'(r_bad), 32'd0);
        chk("held_mdr_in", 32'(MDR_In), 32'(m_mdr_in));

        for (int k = 0; k < 20; k++) begin
            int          kind;
            bit          io;
            logic [15:0] mar;
            kind = int'($urandom_range(0, 2));
            io   = ($urandom_range(0, 3) == 0);
            mar  = io ? 16'hFFFF : 16'($urandom);
            access(kind != 1, kind != 0, mar, 16'($urandom), 16'($urandom),
                   16'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
